// File: rtl/link_msg_pkg.sv
// link_msg_pkg: message definitions for the 64-bit root/leaf parent link.
// The root-side transmitter and the leaf-side deframer both use this package.
//
// Contents:
//   msg_type_e      - message type codes carried in header bits [63:56]
//   HDR_*_LSB       - header field bit positions
//   link_hdr_t      - header struct (type, destination, payload word count, test id)
//   hdr_unpack      - splits a raw link word into header fields
//   hdr_pack        - assembles a raw link word from header fields
//   msg_type_known  - true for a type code this link defines
package link_msg_pkg;

    typedef enum logic [7:0] {
        MSG_MEASUREMENT  = 8'h01,
        MSG_START_DECODE = 8'h02,
        MSG_SOFT_RESET   = 8'h03
    } msg_type_e;

    localparam int unsigned HDR_TYPE_LSB  = 56;
    localparam int unsigned HDR_DEST_LSB  = 48;
    localparam int unsigned HDR_COUNT_LSB = 32;
    localparam int unsigned HDR_ID_LSB    = 0;

    typedef struct packed {
        logic [7:0]  msg_type;
        logic [7:0]  dest;
        logic [15:0] word_count;
        logic [31:0] test_id;
    } link_hdr_t;

    function automatic link_hdr_t hdr_unpack(logic [63:0] word);
        link_hdr_t h;
        h.msg_type   = word[HDR_TYPE_LSB  +: 8];
        h.dest       = word[HDR_DEST_LSB  +: 8];
        h.word_count = word[HDR_COUNT_LSB +: 16];
        h.test_id    = word[HDR_ID_LSB    +: 32];
        return h;
    endfunction

    function automatic logic [63:0] hdr_pack(link_hdr_t h);
        logic [63:0] word;
        word                        = '0;
        word[HDR_TYPE_LSB  +: 8]    = h.msg_type;
        word[HDR_DEST_LSB  +: 8]    = h.dest;
        word[HDR_COUNT_LSB +: 16]   = h.word_count;
        word[HDR_ID_LSB    +: 32]   = h.test_id;
        return word;
    endfunction

    function automatic logic msg_type_known(logic [7:0] t);
        return (t == MSG_MEASUREMENT) || (t == MSG_START_DECODE) || (t == MSG_SOFT_RESET);
    endfunction

endpackage

// File: rtl/leaf_parent_rx_deframer_if.sv
// leaf_parent_rx_deframer_if: bundles the two streaming channels of the leaf deframer.
//
// Signals:
//   parent_rx_data/valid/ready - 64-bit valid/ready parent link (root hub -> leaf)
//   meas_data/round/valid/ready - one syndrome round per handshake (leaf -> decoder)
//
// Modports:
//   master - the deframer: sinks the parent link and sources measurement rounds
//   slave  - its environment: sources the parent link and sinks measurement rounds
interface leaf_parent_rx_deframer_if #(
    parameter int unsigned MEAS_BITS = 108,
    parameter int unsigned ROUND_W   = 3
);

    logic [63:0]          parent_rx_data;
    logic                 parent_rx_valid;
    logic                 parent_rx_ready;

    logic [MEAS_BITS-1:0] meas_data;
    logic [ROUND_W-1:0]   meas_round;
    logic                 meas_valid;
    logic                 meas_ready;

    modport master (
        input  parent_rx_data,
        input  parent_rx_valid,
        output parent_rx_ready,
        output meas_data,
        output meas_round,
        output meas_valid,
        input  meas_ready
    );

    modport slave (
        output parent_rx_data,
        output parent_rx_valid,
        input  parent_rx_ready,
        input  meas_data,
        input  meas_round,
        input  meas_valid,
        output meas_ready
    );

endinterface

// File: rtl/round_assembler.sv
// round_assembler: gathers the payload words of one syndrome round into a MEAS_BITS vector.
// Word k of a round lands in bits [64k+63:64k]; bits of the last word at or above
// MEAS_BITS are dropped. A word-in-round counter selects the slot and wraps after
// WORDS_PER_ROUND words.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - restart at word 0 of a round (new frame / soft reset)
//   word_en     - a payload word is being accepted this cycle
//   word        - the payload word
//   round_last  - the next accepted word completes the round
//   meas_data   - assembled round; holds its value while no words are accepted
module round_assembler #(
    parameter int unsigned MEAS_BITS       = 108,
    parameter int unsigned WORDS_PER_ROUND = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 word_en,
    input  logic [63:0]          word,
    output logic                 round_last,
    output logic [MEAS_BITS-1:0] meas_data
);

    localparam int unsigned IDX_W = (WORDS_PER_ROUND > 1) ? $clog2(WORDS_PER_ROUND) : 1;

    logic [IDX_W-1:0]     idx_q;
    logic [MEAS_BITS-1:0] buf_q;
    logic [MEAS_BITS-1:0] buf_d;

    assign round_last = (idx_q == IDX_W'(WORDS_PER_ROUND - 1));
    assign meas_data  = buf_q;

    // Per-bit slot select keeps the store exactly MEAS_BITS wide, so the
    // ignored top bits of the last word never reach a register.
    always_comb begin
        buf_d = buf_q;
        for (int b = 0; b < int'(MEAS_BITS); b++) begin
            if (b / 64 == int'(idx_q)) begin
                buf_d[b] = word[6'(b % 64)];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            buf_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
        end else if (word_en) begin
            buf_q <= buf_d;
            idx_q <= round_last ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/leaf_parent_rx_deframer.sv
// leaf_parent_rx_deframer: leaf-side receiver for the root hub's downstream parent link.
// Parses framed messages, unpacks MEASUREMENT payloads into per-round syndrome vectors
// for the decoder, and turns START_DECODE / SOFT_RESET headers into one-cycle pulses.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   bus (master)    - parent_rx_* link in, meas_* rounds out (see leaf_parent_rx_deframer_if)
//   test_id         - test id of the last accepted MEASUREMENT header
//   start_decoding  - one-cycle pulse after a START_DECODE header for this leaf
//   soft_reset      - one-cycle pulse after a SOFT_RESET header for this leaf
//   frame_error     - sticky; cleared by reset or an accepted SOFT_RESET
//   stat_frames/stat_dropped/stat_rounds - saturating counters, present only when
//                     LEAF_RX_STATS_EN is defined
//
// Frame errors: unknown type for this leaf, a trailing partial round, or more than
// CODE_DISTANCE rounds. Partial and excess rounds are consumed and never emitted.
module leaf_parent_rx_deframer
    import link_msg_pkg::*;
#(
    parameter int unsigned CODE_DISTANCE          = 5,
    parameter int unsigned LOGICAL_QUBITS_PER_DIM = 3,
    parameter int unsigned FPGA_ID                = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    leaf_parent_rx_deframer_if.master   bus,
    output logic [31:0]                 test_id,
    output logic                        start_decoding,
    output logic                        soft_reset,
    output logic                        frame_error
`ifdef LEAF_RX_STATS_EN
    ,
    output logic [31:0]                 stat_frames,
    output logic [31:0]                 stat_dropped,
    output logic [31:0]                 stat_rounds
`endif
);

    localparam int unsigned MEAS_BITS =
        LOGICAL_QUBITS_PER_DIM ** 2 * (CODE_DISTANCE ** 2 - 1) / 2;
    localparam int unsigned WORDS_PER_ROUND = (MEAS_BITS + 63) / 64;
    localparam int unsigned ROUND_W = (CODE_DISTANCE > 1) ? $clog2(CODE_DISTANCE) : 1;
    // One extra code point so the counter can sit at CODE_DISTANCE (all rounds used).
    localparam int unsigned RCNT_W  = $clog2(CODE_DISTANCE + 1);

    typedef enum logic [1:0] {
        StHeader,
        StPayload,
        StEmit,
        StDrop
    } state_e;

    state_e             state_q;
    logic [15:0]        words_left_q;
    logic [RCNT_W-1:0]  rounds_q;
    logic               rx_ready_q;
    logic               meas_valid_q;
    logic [ROUND_W-1:0] meas_round_q;

    link_hdr_t          hdr;
    logic               beat;
    logic               hdr_fire;
    logic               word_fire;
    logic               dest_match;
    logic               has_payload;
    logic               frame_last;
    logic               round_room;
    logic               round_last;
    logic               meas_start;
    logic               soft_fire;

    assign hdr         = hdr_unpack(bus.parent_rx_data);
    assign beat        = bus.parent_rx_valid && rx_ready_q;
    assign hdr_fire    = beat && (state_q == StHeader);
    assign word_fire   = beat && (state_q == StPayload);
    assign dest_match  = (hdr.dest == 8'(FPGA_ID));
    assign has_payload = (hdr.word_count != 16'd0);
    assign frame_last  = (words_left_q == 16'd1);
    assign round_room  = (rounds_q < RCNT_W'(CODE_DISTANCE));
    assign meas_start  = hdr_fire && dest_match && (hdr.msg_type == MSG_MEASUREMENT)
                         && has_payload;
    assign soft_fire   = hdr_fire && dest_match && (hdr.msg_type == MSG_SOFT_RESET);

    assign bus.parent_rx_ready = rx_ready_q;
    assign bus.meas_valid      = meas_valid_q;
    assign bus.meas_round      = meas_round_q;

    round_assembler #(
        .MEAS_BITS       (MEAS_BITS),
        .WORDS_PER_ROUND (WORDS_PER_ROUND)
    ) u_round_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (meas_start || soft_fire),
        .word_en    (word_fire),
        .word       (bus.parent_rx_data),
        .round_last (round_last),
        .meas_data  (bus.meas_data)
    );

    // parent_rx_ready is kept as its own register, low exactly while in StEmit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StHeader;
            words_left_q   <= '0;
            rounds_q       <= '0;
            rx_ready_q     <= 1'b1;
            meas_valid_q   <= 1'b0;
            meas_round_q   <= '0;
            test_id        <= '0;
            start_decoding <= 1'b0;
            soft_reset     <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            start_decoding <= 1'b0;
            soft_reset     <= 1'b0;

            case (state_q)
                StHeader: begin
                    if (hdr_fire) begin
                        if (!dest_match) begin
                            if (has_payload) begin
                                state_q      <= StDrop;
                                words_left_q <= hdr.word_count;
                            end
                        end else begin
                            case (hdr.msg_type)
                                MSG_MEASUREMENT: begin
                                    if (has_payload) begin
                                        state_q      <= StPayload;
                                        words_left_q <= hdr.word_count;
                                        rounds_q     <= '0;
                                        test_id      <= hdr.test_id;
                                    end
                                end
                                MSG_START_DECODE: begin
                                    start_decoding <= 1'b1;
                                end
                                MSG_SOFT_RESET: begin
                                    soft_reset  <= 1'b1;
                                    frame_error <= 1'b0;
                                    rounds_q    <= '0;
                                    test_id     <= '0;
                                end
                                default: begin
                                    frame_error <= 1'b1;
                                    if (has_payload) begin
                                        state_q      <= StDrop;
                                        words_left_q <= hdr.word_count;
                                    end
                                end
                            endcase
                        end
                    end
                end

                StPayload: begin
                    if (word_fire) begin
                        words_left_q <= words_left_q - 16'd1;
                        if (round_last) begin
                            if (round_room) begin
                                state_q      <= StEmit;
                                rx_ready_q   <= 1'b0;
                                meas_valid_q <= 1'b1;
                                meas_round_q <= ROUND_W'(rounds_q);
                            end else begin
                                // Excess round: consumed, never presented.
                                frame_error <= 1'b1;
                                if (frame_last) begin
                                    state_q <= StHeader;
                                end
                            end
                        end else if (frame_last) begin
                            // Frame ended mid-round: drop the partial round.
                            frame_error <= 1'b1;
                            state_q     <= StHeader;
                        end
                    end
                end

                StEmit: begin
                    if (bus.meas_ready) begin
                        meas_valid_q <= 1'b0;
                        rx_ready_q   <= 1'b1;
                        rounds_q     <= rounds_q + 1'b1;
                        state_q      <= (words_left_q != 16'd0) ? StPayload : StHeader;
                    end
                end

                StDrop: begin
                    if (beat) begin
                        words_left_q <= words_left_q - 16'd1;
                        if (frame_last) begin
                            state_q <= StHeader;
                        end
                    end
                end

                default: begin
                    state_q <= StHeader;
                end
            endcase
        end
    end

`ifdef LEAF_RX_STATS_EN
    logic drop_entry;
    logic emit_fire;

    assign drop_entry = hdr_fire && has_payload
                        && (!dest_match || !msg_type_known(hdr.msg_type));
    assign emit_fire  = (state_q == StEmit) && bus.meas_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames  <= '0;
            stat_dropped <= '0;
            stat_rounds  <= '0;
        end else begin
            if (hdr_fire && (stat_frames != '1)) begin
                stat_frames <= stat_frames + 32'd1;
            end
            if (drop_entry && (stat_dropped != '1)) begin
                stat_dropped <= stat_dropped + 32'd1;
            end
            if (emit_fire && (stat_rounds != '1)) begin
                stat_rounds <= stat_rounds + 32'd1;
            end
        end
    end
`endif

endmodule
